// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction formats, opcodes, immediate ranges and
// the field packer used by the instruction encoder.
package rv32i_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_S = 2'd2,
    FMT_B = 2'd3
  } fmt_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

  // Only imm[12:0] can reach the word; higher bits are dropped by truncation.
  function automatic logic [31:0] pack_instr(
    input fmt_e        fmt,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [12:0] imm
  );
    logic [31:0] word;
    case (fmt)
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      default: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Combinational immediate range check: flags immediates that do not fit the
// encodable field of the given format (B also requires an even offset).
module imm_range_chk
  import rv32i_pkg::*;
#(
  parameter int W = 32
) (
  input  fmt_e         fmt,
  input  logic [W-1:0] imm,
  output logic         err
);

  logic signed [W-1:0] w_imm;
  assign w_imm = $signed(imm);

  always_comb begin
    err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: err = (w_imm < IMM12_MIN) || (w_imm > IMM12_MAX);
      FMT_B:        err = (w_imm < IMM13_MIN) || (w_imm > IMM13_MAX) || imm[0];
      default:      err = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Pipelined RV32I encoder: packs field sets into R/I/S/B words with sequential
// addresses behind a single output register. Define IMM_CHECK_EN to enable out_err.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int                INSTRUCTION = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             fmt,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  input  logic [INSTRUCTION-1:0] imm,
  input  logic                   addr_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTRUCTION-1:0] out_instr,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_err,
  output enc_state_e             dbg_state
);

  // Handshake: a field set is captured when in_valid && in_ready; a word leaves
  // when out_valid && out_ready. in_ready = !out_valid || out_ready, so a held
  // word that is leaving this cycle can be replaced in the same edge.

  enc_state_e             r_state;
  enc_state_e             w_state_nxt;
  logic                   w_capture;
  logic                   w_transfer;
  fmt_e                   w_fmt;
  logic [31:0]            w_packed;
  logic [ADDR_W-1:0]      w_base;
  logic [INSTRUCTION-1:0] r_instr;
  logic [ADDR_W-1:0]      r_addr;
  logic [ADDR_W-1:0]      r_next_addr;

  assign w_fmt      = fmt_e'(fmt);
  assign w_capture  = in_valid && in_ready;
  assign w_transfer = out_valid && out_ready;
  assign w_base     = addr_clr ? BASE_ADDR : r_next_addr;
  assign w_packed   = pack_instr(w_fmt, opcode, rd, rs1, rs2, funct3, funct7, imm[12:0]);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_capture)                w_state_nxt = ST_FULL;
      ST_FULL:  if (w_transfer && !w_capture) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (r_state == ST_FULL);
    in_ready  = !out_valid || out_ready;
    dbg_state = r_state;
  end

  // addr_clr only redirects the counter; a word already held keeps its address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr     <= '0;
      r_addr      <= BASE_ADDR;
      r_next_addr <= BASE_ADDR;
    end else if (w_capture) begin
      r_instr     <= INSTRUCTION'(w_packed);
      r_addr      <= w_base;
      r_next_addr <= w_base + ADDR_W'(4);
    end else if (addr_clr) begin
      r_next_addr <= BASE_ADDR;
    end
  end

  assign out_instr = r_instr;
  assign out_addr  = r_addr;

`ifdef IMM_CHECK_EN
  logic w_err;
  logic r_err;

  imm_range_chk #(.W(INSTRUCTION)) u_imm_range_chk (
    .fmt (w_fmt),
    .imm (imm),
    .err (w_err)
  );

  always_ff @(posedge clk) begin
    if (reset)          r_err <= 1'b0;
    else if (w_capture) r_err <= w_err;
  end

  assign out_err = r_err;
`else
  logic w_unused_imm;
  assign w_unused_imm = ^imm[INSTRUCTION-1:13];
  assign out_err      = 1'b0;
`endif

endmodule
